// File: rtl/button_event_decoder_pkg.sv
// btn_pkg: FSM state type and counter sizing shared by the button event decoder.
// Compile option: BTN_AUTOREPEAT_EN sizes the counter for repeat counting as well.
package btn_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, LONG = 2'd2} btn_state_e;

    // The counter is cleared on every transition, so it only has to reach the larger
    // terminal count in use.
    function automatic int cnt_width(input int long_c, input int repeat_c);
        int m;
        m = (long_c > repeat_c) ? long_c : repeat_c;
`ifndef BTN_AUTOREPEAT_EN
        m = long_c;
`endif
        return $clog2(m);
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// btn_evt_if: debounced button level and enable in, event pulses and hold levels out.
// master: drives btn_level/enable, observes events; slave: the decoder.
interface btn_evt_if;
    logic btn_level;
    logic enable;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;
    logic long_held;

    modport master (
        output btn_level, enable,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, long_held
    );

    modport slave (
        input  btn_level, enable,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, long_held
    );
endinterface

// File: rtl/button_event_decoder_edge.sv
// btn_edge_detect: registers the previous button sample and flags rising/falling edges.
// Ports: clk, rst_n (async, active-low), btn_level_i, rise_o, fall_o.
module btn_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level_i,
    output logic rise_o,
    output logic fall_o
);
    logic btn_q;

    // Resetting to 1 makes a button held through reset look already pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_q <= 1'b1;
        else        btn_q <= btn_level_i;
    end

    assign rise_o = btn_level_i & ~btn_q;
    assign fall_o = ~btn_level_i & btn_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/long/repeat pulses.
// Ports: clk, rst_n (async, active-low), bus (btn_evt_if.slave).
// Parameters: LONG_CYCLES press-to-long hold, REPEAT_CYCLES auto-repeat period (both >= 2).
// Compile option: BTN_AUTOREPEAT_EN enables repeat pulses; otherwise repeat_pulse is 0.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input logic       clk,
    input logic       rst_n,
    btn_evt_if.slave  bus
);
    localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_PRESSED = PRESSED;
    localparam logic [1:0] S_LONG    = LONG;
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_TC = CW'(REPEAT_CYCLES - 1);
`endif

    logic          rise, fall;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;
    logic          held_q, long_held_q;

    btn_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level_i (bus.btn_level),
        .rise_o      (rise),
        .fall_o      (fall)
    );

    // Release outranks a coinciding terminal count because fall is tested first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (rise) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
                S_PRESSED: if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_TC) begin
                    state_d = S_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                S_LONG: if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    cnt_d    = (cnt_q == REP_TC) ? '0 : cnt_q + CW'(1);
                    repeat_d = (cnt_q == REP_TC);
`else
                    cnt_d = '0;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // held/long_held are registered from the next state so they move with the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            long_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= (state_d == S_PRESSED) || (state_d == S_LONG);
            long_held_q <= (state_d == S_LONG);
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
    assign bus.long_held     = long_held_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: scoreboard bench; stimulus queues expected events, a monitor checks them.
module tb_button_event_decoder;
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];

    btn_evt_if bus ();

    button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Any pulse counts as an output event; each one is matched against the queue head.
    always @(negedge clk) begin
        logic [3:0] p;
        int k;
        ev_t e;
        p = {bus.repeat_pulse, bus.long_pulse, bus.release_pulse, bus.press_pulse};
        k = p[0] ? K_PRESS : p[1] ? K_RELEASE : p[2] ? K_LONG : K_REPEAT;
        if ($countones(p) > 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL one_hot: pulses=%b, expected at most one high (cycle %0d)", p, cyc);
        end else if (p != 4'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL event: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                             k, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        bus.btn_level = 1'b0;
        bus.enable    = 1'b1;
        tick(3);
        check("reset_held", int'(bus.held), 0);
        check("reset_long_held", int'(bus.long_held), 0);
        check("reset_pulses", int'({bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse}), 0);
        rst_n = 1'b1;
        tick(3);

        // short press
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        tick(1);
        check("short_held", int'(bus.held), 1);
        tick(2);
        bus.btn_level = 1'b0;
        push(K_RELEASE, c + 4);
        tick(1);
        check("short_held_after", int'(bus.held), 0);
        tick(4);

        // long hold with auto-repeat
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        push(K_LONG, c + 9);
`ifdef BTN_AUTOREPEAT_EN
        for (int i = 0; i < 4; i++) push(K_REPEAT, c + 13 + 4 * i);
`endif
        tick(8);
        check("pre_long_long_held", int'(bus.long_held), 0);
        tick(4);
        check("long_long_held", int'(bus.long_held), 1);
        check("long_held", int'(bus.held), 1);
        tick(13);
        bus.btn_level = 1'b0;
        push(K_RELEASE, c + 26);
        tick(1);
        check("long_release_long_held", int'(bus.long_held), 0);
        tick(4);

        // release on the long terminal-count edge
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        tick(8);
        bus.btn_level = 1'b0;
        push(K_RELEASE, c + 9);
        tick(1);
        check("collide_held", int'(bus.held), 0);
        check("collide_long_held", int'(bus.long_held), 0);
        tick(4);

        // enable drop while long-held
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        push(K_LONG, c + 9);
        tick(10);
        check("en_long_held", int'(bus.long_held), 1);
        bus.enable = 1'b0;
        tick(2);
        check("en_off_held", int'(bus.held), 0);
        check("en_off_long_held", int'(bus.long_held), 0);
        bus.enable = 1'b1;
        tick(5);
        check("en_back_held", int'(bus.held), 0);
        bus.btn_level = 1'b0;
        tick(2);
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        tick(3);
        check("repress_held", int'(bus.held), 1);

        // asynchronous reset mid-hold, button kept down through reset release
        rst_n = 1'b0;
        #1;
        check("async_rst_held", int'(bus.held), 0);
        check("async_rst_long_held", int'(bus.long_held), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("thru_rst_held", int'(bus.held), 0);
        bus.btn_level = 1'b0;
        tick(2);
        c = cyc;
        bus.btn_level = 1'b1;
        push(K_PRESS, c + 1);
        tick(2);
        bus.btn_level = 1'b0;
        push(K_RELEASE, c + 3);
        tick(5);

        check("leftover_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the clean, synchronous button level produced by the debouncer into one-cycle event pulses: press, release, long-press and auto-repeat. Sits directly downstream of the debouncer, one instance per button, and feeds the control FSMs that act on user input. All outputs are registered and free of glitches.

## Interface

- LONG_CYCLES, 50_000_000: hold time, in clk cycles, from press to long-press event; must be >= 2
- REPEAT_CYCLES, 10_000_000: period, in clk cycles, of auto-repeat pulses while long-held; must be >= 2
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- btn_level  in  1  debounced button level, 1 = pressed; already synchronous to clk
- enable  in  1  1 = decode events; 0 = force idle
- press_pulse  out  1  one-cycle pulse on press
- release_pulse  out  1  one-cycle pulse on release
- long_pulse  out  1  one-cycle pulse when hold reaches LONG_CYCLES
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while long-held
- held  out  1  level, 1 while state is PRESSED or LONG
- long_held  out  1  level, 1 while state is LONG

## Operation

- btn_q holds the previous sample of btn_level. Rise = btn_level & ~btn_q. Fall = ~btn_level & btn_q.
- FSM states are IDLE, PRESSED and LONG. One counter, cnt, is shared. Its width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). It counts up and never wraps, because it is cleared on every transition.
- IDLE, on rise: go to PRESSED, cnt <= 0, press_pulse <= 1.
- PRESSED:
  - On fall: go to IDLE, release_pulse <= 1.
  - Otherwise, when cnt == LONG_CYCLES-1: go to LONG, cnt <= 0, long_pulse <= 1.
  - Otherwise: cnt++.
- LONG:
  - On fall: go to IDLE, release_pulse <= 1.
  - Otherwise, when cnt == REPEAT_CYCLES-1: cnt <= 0, repeat_pulse <= 1.
  - Otherwise: cnt++.
- Release has priority. If fall coincides with the long or repeat terminal count, only release_pulse fires.
- enable = 0:
  - State is forced to IDLE, cnt <= 0, and all pulses are 0.
  - No release_pulse is issued for an interrupted hold.
  - btn_q keeps tracking. Re-enabling while the button is held produces no press until the button is released and pressed again.
- At most one pulse output is high in any cycle.

## Timing

- Reset values:
  - state IDLE, cnt 0.
  - All pulse outputs 0; held 0; long_held 0.
  - btn_q 1, so a button held through reset release produces no press until it is released and pressed again.
- Latency: a pulse is high in the cycle immediately after the clk edge that samples the triggering btn_level value. Every pulse is exactly one cycle wide.
- held and long_held change on the same edge as their corresponding pulses.
- long_pulse follows press_pulse by exactly LONG_CYCLES cycles when btn_level stays 1.
- The first repeat_pulse follows long_pulse by REPEAT_CYCLES cycles. Later repeat pulses are spaced REPEAT_CYCLES apart.
- Asserting rst_n low mid-hold clears all state and outputs immediately, without waiting for a clock edge.

## Configuration

- BTN_AUTOREPEAT_EN defined:
  - The LONG-state repeat counting described above is compiled in.
- BTN_AUTOREPEAT_EN undefined:
  - repeat_pulse is tied to 0.
  - In LONG, cnt holds at 0.
  - REPEAT_CYCLES is ignored.
  - cnt width is $clog2(LONG_CYCLES).
  - All other behaviour is identical.

## Structure

- Package btn_pkg contains:
  - typedef enum logic [1:0] btn_state_e {IDLE, PRESSED, LONG}.
  - Function cnt_width(long, repeat), returning the counter width.
- Sub-module btn_edge_detect contains btn_q with its reset-to-1 behaviour and produces rise and fall. It is instantiated once.
- The FSM, counter and output registers live in button_event_decoder.

## Test plan

All scenarios use LONG_CYCLES=8 and REPEAT_CYCLES=4, with BTN_AUTOREPEAT_EN defined unless noted.

- Short press: btn_level 0→1 at edge 5, 1→0 at edge 8 -> press_pulse high for cycle 6 only; release_pulse high for cycle 9 only; held high for cycles 6–8; no long_pulse.
- Long hold: btn_level 1 from edge 5 to edge 30 -> press_pulse at cycle 6; long_pulse at cycle 14; repeat_pulse at cycles 18, 22, 26 and 30; release_pulse at cycle 31.
- Release colliding with terminal count: fall sampled on the edge where cnt == 7 in PRESSED -> release_pulse only, no long_pulse, state IDLE.
- Held through reset: btn_level = 1 while rst_n is released, then held for 20 cycles -> no pulses. A subsequent release and re-press gives press_pulse 1 cycle later.
- Enable drop mid-hold: enable drops to 0 in LONG, then returns to 1 while btn_level is still 1 -> held and long_held go to 0; no release_pulse; no press_pulse until a fresh 0→1.
- Macro off (BTN_AUTOREPEAT_EN undefined): long-hold stimulus -> long_pulse at cycle 14, repeat_pulse constant 0, release_pulse at cycle 31.
